// File: rtl/filter_sched_pkg.sv
// rtl/filter_sched_pkg.sv - shared widths and scheduler state encoding for the PNG filter row scheduler
package filter_sched_pkg;

    localparam int SIZE_W_WD      = 12;
    localparam int SIZE_H_WD      = 12;
    localparam int FILTER_ENUM_WD = 3;
    localparam int WDOG_WD        = 16;

    localparam int ST_WD = 3;
    localparam logic [ST_WD-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_WD-1:0] ST_WAIT   = 3'd1;
    localparam logic [ST_WD-1:0] ST_LAUNCH = 3'd2;
    localparam logic [ST_WD-1:0] ST_STREAM = 3'd3;
    localparam logic [ST_WD-1:0] ST_DRAIN  = 3'd4;
    localparam logic [ST_WD-1:0] ST_NEXT   = 3'd5;
    localparam logic [ST_WD-1:0] ST_FIN    = 3'd6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/filter_sched_cnt.sv
// rtl/filter_sched_cnt.sv - loadable saturating down-counter shared by stream length and watchdog
module filter_sched_cnt #(
    parameter int WD = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [WD-1:0] load_val,
    input  logic          dec,
    output logic [WD-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/filter_sched.sv
// rtl/filter_sched.sv - per-frame row scheduler: gates source stream, launches filter passes, tracks ping-pong buffers
module filter_sched
    import filter_sched_pkg::*;
#(
    parameter int FLT_DLY_CYC = 5,
    parameter int ROOM_WD     = 12,
    parameter int TMO_CYC     = 65535
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE_W_WD-1:0] cfg_w_i,
    input  logic [SIZE_H_WD-1:0] cfg_h_i,
    input  logic                 frm_start_i,
    input  logic                 frm_abort_i,
    output logic                 frm_done_o,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic                 src_line_rdy_i,
    output logic                 src_en_o,
    input  logic [ROOM_WD-1:0]   dst_room_i,
    output logic                 flt_start_o,
    input  logic                 flt_done_i,
    input  logic [SIZE_H_WD-1:0] flt_cnt_h_i,
    output logic                 buf_sel_o,
    output logic [SIZE_H_WD-1:0] row_o
);

    localparam int CMP_WD = max_int(ROOM_WD, SIZE_W_WD + 1);
    localparam logic [WDOG_WD-1:0] TMO_VAL = WDOG_WD'(TMO_CYC);

    // A watchdog no longer than the compare phase would trip on every healthy row.
    if (TMO_CYC < 0 || TMO_CYC > 65535 || (TMO_CYC != 0 && TMO_CYC <= FLT_DLY_CYC)) begin : g_bad_tmo
        $error("filter_sched: TMO_CYC out of range");
    end

    logic [ST_WD-1:0]     state;
    logic [ST_WD-1:0]     state_nxt;
    logic [SIZE_W_WD-1:0] w_r;
    logic [SIZE_H_WD-1:0] h_r;
    logic [SIZE_H_WD-1:0] row_r;
    logic                 buf_r;
    logic                 abort_pend;

    logic                 cnt_load;
    logic [WDOG_WD-1:0]   cnt_load_val;
    logic                 cnt_dec;
    logic [WDOG_WD-1:0]   cnt;
    logic                 cnt_zero;

    logic start_ok;
    logic room_ok;
    logic last_beat;
    logic last_row;
    logic timeout;

    filter_sched_cnt #(.WD(WDOG_WD)) u_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign start_ok  = frm_start_i && (cfg_w_i != '0) && (cfg_h_i != '0);
    // One extra word of room is kept for the filter-type byte that precedes each row.
    assign room_ok   = CMP_WD'(dst_room_i) >= (CMP_WD'(w_r) + CMP_WD'(1));
    assign last_beat = (cnt == WDOG_WD'(1));
    assign last_row  = (row_r == (h_r - 1'b1));
    assign timeout   = (TMO_CYC != 0) && cnt_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (frm_abort_i) begin
                    state_nxt = ST_FIN;
                end else if (src_line_rdy_i && room_ok) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nxt = ST_STREAM;
            ST_STREAM: if (last_beat) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (flt_done_i) begin
                    state_nxt = ST_NEXT;
                end else if (timeout) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_NEXT:   state_nxt = (last_row || abort_pend || frm_abort_i) ? ST_FIN : ST_WAIT;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state != ST_IDLE);
        flt_start_o  = (state == ST_LAUNCH);
        src_en_o     = (state == ST_STREAM);
        frm_done_o   = (state == ST_FIN);
        err_o        = ((state == ST_IDLE) && frm_start_i && !start_ok)
                    || ((state == ST_NEXT) && (flt_cnt_h_i != row_r))
                    || ((state == ST_DRAIN) && !flt_done_i && timeout)
                    || ((state != ST_DRAIN) && flt_done_i);
        // The stream length is loaded at launch; the watchdog reload rides on the last stream beat.
        cnt_load     = (state == ST_LAUNCH) || ((state == ST_STREAM) && last_beat);
        cnt_load_val = (state == ST_LAUNCH) ? WDOG_WD'(w_r) : TMO_VAL;
        cnt_dec      = (state == ST_STREAM) || (state == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_r        <= '0;
            h_r        <= '0;
            row_r      <= '0;
            buf_r      <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && frm_start_i) begin
                w_r   <= cfg_w_i;
                h_r   <= cfg_h_i;
                row_r <= '0;
                buf_r <= 1'b0;
            end
            if (state == ST_NEXT) begin
                row_r <= row_r + 1'b1;
                buf_r <= ~buf_r;
            end
            if (state == ST_FIN) begin
                row_r <= '0;
            end
            if (frm_abort_i && ((state == ST_LAUNCH) || (state == ST_STREAM) || (state == ST_DRAIN))) begin
                abort_pend <= 1'b1;
            end else if (state == ST_FIN) begin
                abort_pend <= 1'b0;
            end
        end
    end

    assign buf_sel_o = buf_r;
    assign row_o     = row_r;

endmodule

// File: tb/tb_filter_sched.sv
// tb/tb_filter_sched.sv - self-checking bench for filter_sched with an engine model and a row-timing reference
module tb_filter_sched;
    import filter_sched_pkg::*;

    localparam int FLT_DLY = 5;
    localparam int TMO     = 50;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [SIZE_W_WD-1:0] cfg_w_i;
    logic [SIZE_H_WD-1:0] cfg_h_i;
    logic                 frm_start_i;
    logic                 frm_abort_i;
    logic                 frm_done_o;
    logic                 busy_o;
    logic                 err_o;
    logic                 src_line_rdy_i;
    logic                 src_en_o;
    logic [11:0]          dst_room_i;
    logic                 flt_start_o;
    logic                 flt_done_i;
    logic [SIZE_H_WD-1:0] flt_cnt_h_i;
    logic                 buf_sel_o;
    logic [SIZE_H_WD-1:0] row_o;

    filter_sched #(.FLT_DLY_CYC(FLT_DLY), .ROOM_WD(12), .TMO_CYC(TMO)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_w_i        (cfg_w_i),
        .cfg_h_i        (cfg_h_i),
        .frm_start_i    (frm_start_i),
        .frm_abort_i    (frm_abort_i),
        .frm_done_o     (frm_done_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .src_line_rdy_i (src_line_rdy_i),
        .src_en_o       (src_en_o),
        .dst_room_i     (dst_room_i),
        .flt_start_o    (flt_start_o),
        .flt_done_i     (flt_done_i),
        .flt_cnt_h_i    (flt_cnt_h_i),
        .buf_sel_o      (buf_sel_o),
        .row_o          (row_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        int abort_row;
        int exp_starts;
        int exp_en;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int eng_done_at = -1;
    int eng_w = 1;
    int eng_row = 0;
    int cnt_h_off = 0;
    bit eng_withhold = 1'b0;
    bit eng_fire = 1'b0;
    bit force_done = 1'b0;

    bit rand_on = 1'b0;
    bit drv_rdy = 1'b1;
    int room_at = -1;
    int frm_cyc = 0;

    int n_start, n_en, n_done, n_err, first_start, first_err, done_cyc;
    int bad_en, bad_buf, bad_row, bad_launch, bad_done;
    int en_from, en_to;

    bit m_wait, m_abort;
    int m_wait_from, m_exp_launch, m_exp_done, m_rows, m_w, m_h;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs for cycle cyc are applied just after its rising edge.
    task automatic edge_step();
        @(posedge clk);
        #1;
        cyc++;
        frm_start_i = 1'b0;
        frm_abort_i = 1'b0;
        eng_fire    = (eng_done_at == cyc) && !eng_withhold;
        flt_done_i  = eng_fire || force_done;
        force_done  = 1'b0;
        flt_cnt_h_i = SIZE_H_WD'(eng_row + cnt_h_off);
        if (rand_on) begin
            src_line_rdy_i = ($urandom_range(0, 3) != 0);
            dst_room_i     = 12'($urandom_range(0, m_w + 3));
        end else begin
            src_line_rdy_i = drv_rdy;
            if (room_at < 0) dst_room_i = 12'd100;
            else dst_room_i = (cyc - frm_cyc >= room_at) ? 12'(m_w + 1) : 12'(m_w);
        end
    endtask

    task automatic sample_step();
        bit exp_en;
        @(negedge clk);
        if (flt_start_o) begin
            if (n_start == 0) first_start = cyc;
            if (cyc != m_exp_launch) bad_launch++;
            if (int'(buf_sel_o) != (n_start % 2)) bad_buf++;
            if (int'(row_o) != n_start) bad_row++;
            m_exp_launch = -1;
            en_from      = cyc + 1;
            en_to        = cyc + m_w;
            eng_done_at  = cyc + 2 * eng_w + FLT_DLY;
            eng_row      = n_start;
            n_start++;
        end
        exp_en = (cyc >= en_from) && (cyc <= en_to);
        if (src_en_o != exp_en) bad_en++;
        if (src_en_o) n_en++;
        if (frm_done_o) begin
            n_done++;
            done_cyc = cyc;
            if (cyc != m_exp_done) bad_done++;
        end
        if (err_o) begin
            if (n_err == 0) first_err = cyc;
            n_err++;
        end
        if (m_wait && cyc >= m_wait_from && src_line_rdy_i && int'(dst_room_i) >= m_w + 1) begin
            m_exp_launch = cyc + 1;
            m_wait = 1'b0;
        end
        if (eng_fire) begin
            m_rows++;
            if (m_rows >= m_h || m_abort) m_exp_done = cyc + 2;
            else begin
                m_wait = 1'b1;
                m_wait_from = cyc + 2;
            end
        end
    endtask

    task automatic step();
        edge_step();
        sample_step();
    endtask

    task automatic clear_mon();
        n_start = 0; n_en = 0; n_done = 0; n_err = 0;
        first_start = -1; first_err = -1; done_cyc = -1;
        bad_en = 0; bad_buf = 0; bad_row = 0; bad_launch = 0; bad_done = 0;
        en_from = -1000; en_to = -1000;
        m_wait = 1'b0; m_abort = 1'b0; m_rows = 0; m_exp_launch = -1; m_exp_done = -1;
    endtask

    task automatic begin_frame(input int w, input int h, input bit rnd, input bit with_abort);
        clear_mon();
        m_w = w; m_h = h; eng_w = w; eng_row = 0;
        rand_on = rnd;
        edge_step();
        cfg_w_i     = SIZE_W_WD'(w);
        cfg_h_i     = SIZE_H_WD'(h);
        frm_start_i = 1'b1;
        frm_abort_i = with_abort;
        frm_cyc     = cyc;
        m_wait      = 1'b1;
        m_wait_from = cyc + 1;
        sample_step();
    endtask

    task automatic run_to_done(input int abort_row, input int limit);
        int k;
        k = 0;
        while (n_done == 0 && k < limit) begin
            edge_step();
            if (abort_row >= 0 && !m_abort && n_start == abort_row + 1 && cyc == en_from) begin
                frm_abort_i = 1'b1;
                m_abort = 1'b1;
            end
            sample_step();
            k++;
        end
        rand_on = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_vec(input string tag, input int exp_starts, input int exp_en, input int exp_err);
        chk({tag, ".starts"}, n_start, exp_starts);
        chk({tag, ".src_en"}, n_en, exp_en);
        chk({tag, ".done"}, n_done, 1);
        chk({tag, ".err"}, n_err, exp_err);
        chk({tag, ".en_window"}, bad_en, 0);
        chk({tag, ".launch_time"}, bad_launch, 0);
        chk({tag, ".buf_sel"}, bad_buf, 0);
        chk({tag, ".row"}, bad_row, 0);
        chk({tag, ".done_time"}, bad_done, 0);
        chk({tag, ".idle"}, busy_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t tbl[5];
        int k, w, h;
        tbl[0] = '{4, 3, -1, 3, 12};
        tbl[1] = '{4, 5, 1, 2, 8};
        tbl[2] = '{1, 1, -1, 1, 1};
        tbl[3] = '{7, 2, 0, 1, 7};
        tbl[4] = '{16, 4, -1, 4, 64};

        rstn = 1'b0;
        cfg_w_i = '0; cfg_h_i = '0; frm_start_i = 1'b0; frm_abort_i = 1'b0;
        src_line_rdy_i = 1'b0; dst_room_i = '0; flt_done_i = 1'b0; flt_cnt_h_i = '0;
        m_w = 1; m_h = 1;
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {flt_start_o, src_en_o, frm_done_o, busy_o, err_o, buf_sel_o, row_o}, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            begin_frame(tbl[i].w, tbl[i].h, 1'b0, 1'b0);
            run_to_done(tbl[i].abort_row, 2000);
            check_vec($sformatf("vec%0d", i), tbl[i].exp_starts, tbl[i].exp_en, 0);
        end

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 4);
            begin_frame(w, h, 1'b1, 1'b0);
            run_to_done(-1, 3000);
            check_vec($sformatf("rnd%0d", i), h, w * h, 0);
        end

        room_at = 20;
        begin_frame(8, 1, 1'b0, 1'b0);
        run_to_done(-1, 500);
        chk("room.launch_offset", first_start - frm_cyc, 21);
        check_vec("room", 1, 8, 0);
        room_at = -1;

        clear_mon();
        edge_step(); cfg_w_i = '0; cfg_h_i = 12'd3; frm_start_i = 1'b1; sample_step();
        chk("bad_w.err", err_o, 1);
        chk("bad_w.busy", busy_o, 0);
        step();
        chk("bad_w.err_pulse", err_o, 0);
        edge_step(); cfg_w_i = 12'd5; cfg_h_i = '0; frm_start_i = 1'b1; sample_step();
        chk("bad_h.err", err_o, 1);
        repeat (5) step();
        chk("bad_cfg.busy", busy_o, 0);
        chk("bad_cfg.starts", n_start, 0);
        chk("bad_cfg.errs", n_err, 2);

        eng_withhold = 1'b1;
        begin_frame(4, 3, 1'b0, 1'b0);
        run_to_done(-1, 500);
        chk("tmo.err_at", first_err - (first_start + 4 + 1), TMO);
        chk("tmo.done_at", done_cyc - (first_start + 4 + 1), TMO + 1);
        chk("tmo.starts", n_start, 1);
        chk("tmo.errs", n_err, 1);
        eng_done_at = -1;
        eng_withhold = 1'b0;

        cnt_h_off = 1;
        begin_frame(2, 2, 1'b0, 1'b0);
        run_to_done(-1, 500);
        check_vec("row_mismatch", 2, 4, 2);
        cnt_h_off = 0;

        begin_frame(2, 2, 1'b0, 1'b1);
        run_to_done(-1, 500);
        check_vec("start_abort", 2, 4, 0);

        drv_rdy = 1'b0;
        begin_frame(3, 2, 1'b0, 1'b0);
        repeat (3) step();
        force_done = 1'b1;
        step();
        chk("done_outside.err", err_o, 1);
        chk("done_outside.busy", busy_o, 1);
        step();
        chk("done_outside.pulse", err_o, 0);
        edge_step(); cfg_w_i = '0; frm_start_i = 1'b1; sample_step();
        chk("start_busy.err", err_o, 0);
        edge_step(); frm_abort_i = 1'b1; sample_step();
        step();
        chk("wait_abort.done", frm_done_o, 1);
        step();
        chk("wait_abort.busy", busy_o, 0);
        chk("wait_abort.starts", n_start, 0);
        drv_rdy = 1'b1;

        begin_frame(8, 2, 1'b0, 1'b0);
        k = 0;
        while (!(n_start == 2 && cyc == en_from + 2) && k < 500) begin
            step();
            k++;
        end
        chk("rst.src_en_before", src_en_o, 1);
        chk("rst.row_before", row_o, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst.async_drop", {src_en_o, busy_o, row_o}, 0);
        eng_done_at = -1;
        @(negedge clk);
        rstn = 1'b1;
        begin_frame(3, 2, 1'b0, 1'b0);
        run_to_done(-1, 500);
        check_vec("after_rst", 2, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
